csa_serial_multiplier: RTL and testbench

//   Unsigned WIDTH x WIDTH iterative multiplier. Accumulates one partial product per cycle

---
 rtl/csa_serial_multiplier_pkg.sv | 13 +
 rtl/csa_serial_multiplier_counter3.sv | 11 +
 rtl/csa_serial_multiplier.sv | 110 +++++++++++
 tb/tb_csa_serial_multiplier.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_serial_multiplier_pkg.sv
// Shared definitions for the carry-save serial multiplier: FSM encodings and default width.
package csa_serial_multiplier_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCUM   = 2'd1,
      S_RESOLVE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/csa_serial_multiplier_counter3.sv
// 3:2 counter: counts the ones among three equal-weight bits.
// out[0] is the sum bit (same weight), out[1] the carry bit (next weight up).
module counter3 (
   input  logic [2:0] in,
   output logic [1:0] out
);

   assign out[0] = ^in;
   assign out[1] = (in[0] & in[1]) | (in[0] & in[2]) | (in[1] & in[2]);

endmodule

// File: rtl/csa_serial_multiplier.sv
// Unsigned WIDTH x WIDTH iterative multiplier: one partial product per cycle into a
// carry-save pair, a single binary add at the end, valid/ready on both sides.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | in_ready high, waiting for operands
//   S_ACCUM   | WIDTH cycles, one partial product folded in per cycle
//   S_RESOLVE | sum_r + carry_r gives the upper half of the product
//   S_DONE    | out_valid high, product held until out_ready
module csa_serial_multiplier
   import csa_serial_multiplier_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int STEP_W = $clog2(WIDTH) + 1;

   state_t              state;
   logic [WIDTH-1:0]    a_r;
   logic [WIDTH-1:0]    b_r;
   logic [WIDTH-1:0]    sum_r;
   logic [WIDTH-1:0]    carry_r;
   logic [WIDTH-1:0]    lo_r;
   logic [STEP_W-1:0]   step;

   logic [WIDTH-1:0]    pp;
   logic [WIDTH-1:0]    s;
   logic [WIDTH-1:0]    c;
   logic [WIDTH-1:0]    hi;

   // b_r shifts right each step, so bit 0 is always the multiplier bit for this step
   assign pp = a_r & {WIDTH{b_r[0]}};

   for (genvar j = 0; j < WIDTH; j++) begin : g_row
      counter3 u_counter3 (
         .in  ({pp[j], carry_r[j], sum_r[j]}),
         .out ({c[j], s[j]})
      );
   end

   // Upper half of a*b never exceeds WIDTH bits, so the adder carry-out is dropped
   assign hi = sum_r + carry_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         product   <= '0;
         a_r       <= '0;
         b_r       <= '0;
         sum_r     <= '0;
         carry_r   <= '0;
         lo_r      <= '0;
         step      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_r      <= a;
                  b_r      <= b;
                  sum_r    <= '0;
                  carry_r  <= '0;
                  lo_r     <= '0;
                  step     <= '0;
                  in_ready <= 1'b0;
                  state    <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               // lo_r fills from the top; after WIDTH shifts step 0's bit sits at bit 0
               lo_r    <= {s[0], lo_r[WIDTH-1:1]};
               sum_r   <= {1'b0, s[WIDTH-1:1]};
               carry_r <= c;
               b_r     <= b_r >> 1;
               step    <= step + STEP_W'(1);
               if (step == STEP_W'(WIDTH - 1)) begin
                  state <= S_RESOLVE;
               end
            end
            S_RESOLVE: begin
               product   <= {hi, lo_r};
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csa_serial_multiplier.sv
// Directed bench for csa_serial_multiplier: an 8-bit instance for the scenarios and a
// 4-bit instance swept over every operand pair with in_valid held high.
module tb_csa_serial_multiplier;

   logic        clk = 1'b0;
   logic        reset;

   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;

   logic        in_valid4;
   logic        in_ready4;
   logic [3:0]  a4;
   logic [3:0]  b4;
   logic        out_valid4;
   logic        out_ready4;
   logic [7:0]  product4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   csa_serial_multiplier #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   csa_serial_multiplier #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .a         (a4),
      .b         (b4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .product   (product4)
   );

   // Issues one operand pair and returns when out_valid is seen; lat counts edges after accept
   task automatic run_op(input logic [7:0] ai, input logic [7:0] bi,
                         output logic [15:0] p, output int lat);
      int n;
      lat = -1;
      n = 0;
      while (!in_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      a = ai;
      b = bi;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (out_valid) lat = n;
      p = product;
   endtask

   task automatic test_reset();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (product !== 16'h0000) begin
         errors++;
         $display("FAIL reset_product: got %h expected 0000", product);
      end
   endtask

   task automatic test_vectors();
      logic [7:0]  va [5] = '{8'd0, 8'd255, 8'd13, 8'd1,   8'd200};
      logic [7:0]  vb [5] = '{8'd0, 8'd255, 8'd11, 8'd200, 8'd1};
      logic [15:0] ve [5] = '{16'h0000, 16'hFE01, 16'h008F, 16'h00C8, 16'h00C8};
      logic [15:0] p;
      int lat;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         run_op(va[i], vb[i], p, lat);
         checks++;
         if (p !== ve[i]) begin
            errors++;
            $display("FAIL product_%0d: got %h expected %h", i, p, ve[i]);
         end
         checks++;
         if (lat !== 9) begin
            errors++;
            $display("FAIL latency_%0d: got %0d expected 9", i, lat);
         end
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_%0d: got out_valid=%b in_ready=%b expected 0/1",
                     i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] p;
      int lat;
      out_ready = 1'b0;
      run_op(8'd37, 8'd5, p, lat);
      checks++;
      if (p !== 16'h00B9) begin
         errors++;
         $display("FAIL bp_product: got %h expected 00b9", p);
      end
      for (int i = 0; i < 5; i++) begin
         a = 8'hAA;
         b = 8'h55;
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         checks++;
         if (product !== 16'h00B9 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_%0d: got product=%h out_valid=%b in_ready=%b expected 00b9/1/0",
                     i, product, out_valid, in_ready);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 16'h00B9) begin
         errors++;
         $display("FAIL bp_release: got out_valid=%b in_ready=%b product=%h expected 0/1/00b9",
                  out_valid, in_ready, product);
      end
      run_op(8'd3, 8'd3, p, lat);
      checks++;
      if (p !== 16'h0009 || lat !== 9) begin
         errors++;
         $display("FAIL bp_next_op: got product=%h lat=%0d expected 0009/9", p, lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_op();
      logic [15:0] p;
      int lat;
      out_ready = 1'b1;
      a = 8'd100;
      b = 8'd100;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0000) begin
         errors++;
         $display("FAIL mid_reset: got in_ready=%b out_valid=%b product=%h expected 1/0/0000",
                  in_ready, out_valid, product);
      end
      run_op(8'd7, 8'd9, p, lat);
      checks++;
      if (p !== 16'h003F || lat !== 9) begin
         errors++;
         $display("FAIL after_reset_op: got product=%h lat=%0d expected 003f/9", p, lat);
      end
      @(posedge clk); #1;
   endtask

   // Held in_valid: accumulate 4 + resolve + done + idle gives 7 cycles between products
   task automatic test_back_to_back_sweep();
      logic [7:0] exp_q [$];
      logic [7:0] e;
      int idx = 0;
      int got = 0;
      int cyc = 0;
      int last = -1;
      bit pending = 1'b0;
      out_ready4 = 1'b1;
      a4 = 4'd0;
      b4 = 4'd0;
      in_valid4 = 1'b1;
      while (got < 256 && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
         if (pending) begin
            idx++;
            a4 = 4'(idx >> 4);
            b4 = 4'(idx);
            pending = 1'b0;
            if (idx >= 256) in_valid4 = 1'b0;
         end
         if (out_valid4) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (product4 !== e) begin
               errors++;
               $display("FAIL sweep_product_%0d: got %h expected %h", got, product4, e);
            end
            if (last >= 0) begin
               checks++;
               if (cyc - last !== 7) begin
                  errors++;
                  $display("FAIL sweep_spacing_%0d: got %0d expected 7", got, cyc - last);
               end
            end
            last = cyc;
            got++;
         end
         if (in_ready4 && in_valid4) begin
            exp_q.push_back(8'(int'(a4) * int'(b4)));
            pending = 1'b1;
         end
      end
      in_valid4 = 1'b0;
      checks++;
      if (got !== 256) begin
         errors++;
         $display("FAIL sweep_count: got %0d expected 256", got);
      end
   endtask

   initial begin
      reset      = 1'b1;
      in_valid   = 1'b0;
      a          = '0;
      b          = '0;
      out_ready  = 1'b1;
      in_valid4  = 1'b0;
      a4         = '0;
      b4         = '0;
      out_ready4 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_vectors();
      test_backpressure();
      test_reset_mid_op();
      test_back_to_back_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
